button_ctrl: RTL and testbench

- Upstream control stage for the LED blinker.
- Conditions three raw active-low pushbuttons: 2-FF synchronise, per-channel debounce, press-edge detect.
- Channel 0 drives the blinker's single-cycle `pause` toggle strobe.
- Channels 1 and 2 step a saturating 4-bit `delay` register (with hold-to-repeat) that feeds the blinker's `delay` input.

---
 rtl/button_ctrl.sv | 123 ++++++++++++
 tb/tb_button_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_ctrl.sv
// Pushbutton front end for the LED blinker: synchronises, debounces and edge-detects
// three active-low buttons, producing a pause strobe and a saturating delay code.
module button_ctrl #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_CYCLES   = 12500000,
    parameter int DELAY_INIT      = 8,
    parameter int DELAY_MIN       = 1,
    parameter int DELAY_MAX       = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] btn_n,
    output logic       pause,
    output logic [3:0] delay,
    output logic [2:0] btn_state
);

    localparam int DW       = $clog2(DEBOUNCE_CYCLES);
    localparam int RW       = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
    localparam int REP_LAST = (REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0;

    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RP_LAST = RW'(REP_LAST);
    localparam logic [3:0]    D_INIT  = 4'(DELAY_INIT);
    localparam logic [3:0]    D_MIN   = 4'(DELAY_MIN);
    localparam logic [3:0]    D_MAX   = 4'(DELAY_MAX);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("button_ctrl: DEBOUNCE_CYCLES must be at least 2");
    end
    if (REPEAT_CYCLES < 0) begin : g_bad_repeat
        $error("button_ctrl: REPEAT_CYCLES must not be negative");
    end
    if (!(DELAY_MIN >= 0 && DELAY_MIN <= DELAY_INIT && DELAY_INIT <= DELAY_MAX && DELAY_MAX <= 15)) begin : g_bad_delay
        $error("button_ctrl: need 0 <= DELAY_MIN <= DELAY_INIT <= DELAY_MAX <= 15");
    end

    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    pressed;
    logic [2:0]    btn_state_d;
    logic [2:0]    press;
    logic [DW-1:0] db_cnt  [3];
    logic [RW-1:0] rep_cnt [1:2];
    logic [2:1]    step;

    assign pressed = ~sync2;
    assign pause   = press[0];

    // A level change is accepted only after it has persisted for DEBOUNCE_CYCLES samples.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1       <= '1;
            sync2       <= '1;
            btn_state   <= '0;
            btn_state_d <= '0;
            press       <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1       <= btn_n;
            sync2       <= sync1;
            btn_state_d <= btn_state;
            press       <= btn_state & ~btn_state_d;
            for (int i = 0; i < 3; i++) begin
                if (pressed[i] == btn_state[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    btn_state[i] <= pressed[i];
                    db_cnt[i]    <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
        end
    end

    // Repeat timing starts only once the press pulse has gone, so the press itself is the first step.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 1; i <= 2; i++) begin
                rep_cnt[i] <= '0;
            end
        end else begin
            for (int i = 1; i <= 2; i++) begin
                if (!btn_state[i] || REPEAT_CYCLES == 0) begin
                    rep_cnt[i] <= '0;
                end else if (btn_state_d[i] && !press[i]) begin
                    if (rep_cnt[i] == RP_LAST) begin
                        rep_cnt[i] <= '0;
                    end else begin
                        rep_cnt[i] <= rep_cnt[i] + RW'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        step = '0;
        for (int i = 1; i <= 2; i++) begin
            step[i] = press[i];
            if (REPEAT_CYCLES > 0 && btn_state[i] && btn_state_d[i] && !press[i] && rep_cnt[i] == RP_LAST) begin
                step[i] = 1'b1;
            end
        end
    end

    // Channel 2 slows the blink (delay up), channel 1 speeds it up; opposing steps cancel.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            delay <= D_INIT;
        end else begin
            case (step)
                2'b10: if (delay != D_MAX) delay <= delay + 4'd1;
                2'b01: if (delay != D_MIN) delay <= delay - 4'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_button_ctrl.sv
// Self-checking bench for button_ctrl: randomised button activity compared every cycle
// against a window-based behavioural model of debounce, press pulses and delay stepping.
module tb_button_ctrl;

    localparam int DB   = 4;
    localparam int RP   = 8;
    localparam int DI   = 8;
    localparam int DMIN = 1;
    localparam int DMAX = 15;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] btn_n;
    logic       pause;
    logic [3:0] delay;
    logic [2:0] btn_state;

    int n_checks = 0;
    int n_pass   = 0;

    button_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_CYCLES  (RP),
        .DELAY_INIT     (DI),
        .DELAY_MIN      (DMIN),
        .DELAY_MAX      (DMAX)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .btn_n    (btn_n),
        .pause    (pause),
        .delay    (delay),
        .btn_state(btn_state)
    );

    always #5 clk = ~clk;

    // Model state: hist[e] is the pressed level seen at edge e (forced released around resets).
    int         cyc = 0;
    logic [2:0] hist [0:16383];
    logic [2:0] m_state = '0;
    logic [2:0] m_rose  = '0;
    logic [2:0] m_press = '0;
    logic [3:0] m_delay = 4'(DI);
    int         rise_edge [3];
    bit         rise_ok   [3];

    function automatic bit win_accept(int e, int ch, logic cur);
        for (int j = 0; j < DB; j++) begin
            int   idx;
            logic v;
            idx = e - 2 - j;
            v = (idx >= 0) ? hist[idx][ch] : 1'b0;
            if (v == cur) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit rep_fire(int ch, int e);
        int age;
        age = e - rise_edge[ch];
        return m_state[ch] && rise_ok[ch] && age > 2 && ((age - 2) % RP) == 0;
    endfunction

    task automatic tick();
        logic [2:0] raw;
        logic       rn;
        logic [2:0] new_state;
        bit         up;
        bit         down;
        int         t;
        raw = ~btn_n;
        rn  = reset_n;
        @(posedge clk);
        cyc++;
        if (!rn) begin
            hist[cyc] = '0;
            hist[cyc-1] = '0;
            m_state = '0;
            m_rose  = '0;
            m_press = '0;
            m_delay = 4'(DI);
            for (int c = 0; c < 3; c++) rise_ok[c] = 1'b0;
        end else begin
            hist[cyc] = raw;
            up   = m_press[2] || rep_fire(2, cyc);
            down = m_press[1] || rep_fire(1, cyc);
            for (int c = 0; c < 3; c++) begin
                new_state[c] = win_accept(cyc, c, m_state[c]) ? ~m_state[c] : m_state[c];
            end
            m_press = m_rose;
            m_rose  = new_state & ~m_state;
            for (int c = 0; c < 3; c++) begin
                if (m_rose[c]) begin
                    rise_edge[c] = cyc;
                    rise_ok[c]   = 1'b1;
                end
                if (!new_state[c]) rise_ok[c] = 1'b0;
            end
            m_state = new_state;
            t = int'(m_delay);
            if (up && !down) t = (t + 1 > DMAX) ? DMAX : t + 1;
            if (down && !up) t = (t - 1 < DMIN) ? DMIN : t - 1;
            m_delay = 4'(t);
        end
        #2;
    endtask

    task automatic test_reset();
        int pulses;
        reset_n = 1'b0;
        btn_n   = 3'b000;
        repeat (3) tick();
        if ({pause, delay, btn_state} !== {1'b0, 4'(DI), 3'b000}) begin
            $display("[TB] FAIL reset_values: got pause=%b delay=%0d state=%b, expected 0/%0d/000", pause, delay, btn_state, DI);
        end else n_pass++;
        n_checks++;
        reset_n = 1'b1;
        pulses  = 0;
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (pause) pulses++;
            if ({pause, delay, btn_state} !== {m_press[0], m_delay, m_state}) begin
                $display("[TB] FAIL reset_release n=%0d: got %b/%0d/%b, expected %b/%0d/%b", n, pause, delay, btn_state, m_press[0], m_delay, m_state);
            end else n_pass++;
            n_checks++;
            if (n == DB + 2) begin
                if (btn_state !== 3'b111) begin
                    $display("[TB] FAIL reset_held_latency: got state=%b, expected 111", btn_state);
                end else n_pass++;
                n_checks++;
            end
        end
        if (pulses != 1) begin
            $display("[TB] FAIL reset_held_pause: got %0d strobes, expected 1", pulses);
        end else n_pass++;
        n_checks++;
        btn_n = 3'b111;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if ({pause, delay, btn_state} !== {m_press[0], m_delay, m_state}) begin
                $display("[TB] FAIL reset_settle n=%0d: got %b/%0d/%b, expected %b/%0d/%b", n, pause, delay, btn_state, m_press[0], m_delay, m_state);
            end else n_pass++;
            n_checks++;
        end
    endtask

    task automatic test_glitch();
        int  pulses;
        int  at;
        bit  seen;
        pulses = 0;
        seen   = 1'b0;
        at     = 0;
        for (int n = 1; n <= 15; n++) begin
            btn_n[0] = (n <= DB - 1) ? 1'b0 : 1'b1;
            tick();
            if (pause) pulses++;
            if (btn_state[0]) seen = 1'b1;
            if ({pause, delay, btn_state} !== {m_press[0], m_delay, m_state}) begin
                $display("[TB] FAIL glitch_short n=%0d: got %b/%0d/%b, expected %b/%0d/%b", n, pause, delay, btn_state, m_press[0], m_delay, m_state);
            end else n_pass++;
            n_checks++;
        end
        if (pulses != 0 || seen) begin
            $display("[TB] FAIL glitch_reject: got %0d strobes, state_seen=%b, expected 0/0", pulses, seen);
        end else n_pass++;
        n_checks++;
        for (int n = 1; n <= 32; n++) begin
            btn_n[0] = (n <= 20) ? 1'b0 : 1'b1;
            tick();
            if (pause) begin
                pulses++;
                at = n;
            end
            if ({pause, delay, btn_state} !== {m_press[0], m_delay, m_state}) begin
                $display("[TB] FAIL glitch_long n=%0d: got %b/%0d/%b, expected %b/%0d/%b", n, pause, delay, btn_state, m_press[0], m_delay, m_state);
            end else n_pass++;
            n_checks++;
        end
        if (pulses != 1 || at != DB + 3) begin
            $display("[TB] FAIL pause_single: got %0d strobes at n=%0d, expected 1 at n=%0d", pulses, at, DB + 3);
        end else n_pass++;
        n_checks++;
    endtask

    task automatic press_once(int ch, string tag);
        int low_len;
        int gap;
        low_len = $urandom_range(6, 9);
        gap     = $urandom_range(7, 10);
        for (int n = 1; n <= low_len + gap; n++) begin
            btn_n[ch] = (n <= low_len) ? 1'b0 : 1'b1;
            tick();
            if ({pause, delay, btn_state} !== {m_press[0], m_delay, m_state}) begin
                $display("[TB] FAIL %s n=%0d: got %b/%0d/%b, expected %b/%0d/%b", tag, n, pause, delay, btn_state, m_press[0], m_delay, m_state);
            end else n_pass++;
            n_checks++;
        end
    endtask

    task automatic test_saturation();
        for (int p = 0; p < 10; p++) press_once(2, "sat_up");
        if (delay !== 4'(DMAX)) begin
            $display("[TB] FAIL sat_up_final: got delay=%0d, expected %0d", delay, DMAX);
        end else n_pass++;
        n_checks++;
        for (int p = 0; p < 20; p++) press_once(1, "sat_down");
        if (delay !== 4'(DMIN)) begin
            $display("[TB] FAIL sat_down_final: got delay=%0d, expected %0d", delay, DMIN);
        end else n_pass++;
        n_checks++;
    endtask

    task automatic test_repeat();
        reset_n = 1'b0;
        btn_n   = 3'b111;
        repeat (2) tick();
        reset_n = 1'b1;
        for (int n = 1; n <= 70; n++) begin
            btn_n[2] = (n > 8 && n <= 48) ? 1'b0 : 1'b1;
            tick();
            if ({pause, delay, btn_state} !== {m_press[0], m_delay, m_state}) begin
                $display("[TB] FAIL repeat n=%0d: got %b/%0d/%b, expected %b/%0d/%b", n, pause, delay, btn_state, m_press[0], m_delay, m_state);
            end else n_pass++;
            n_checks++;
        end
        if (delay !== 4'd13) begin
            $display("[TB] FAIL repeat_final: got delay=%0d, expected 13", delay);
        end else n_pass++;
        n_checks++;
    endtask

    task automatic test_simultaneous();
        int pulses;
        pulses = 0;
        for (int n = 1; n <= 32; n++) begin
            btn_n = (n <= 20) ? 3'b000 : 3'b111;
            tick();
            if (pause) pulses++;
            if ({pause, delay, btn_state} !== {m_press[0], m_delay, m_state}) begin
                $display("[TB] FAIL simul n=%0d: got %b/%0d/%b, expected %b/%0d/%b", n, pause, delay, btn_state, m_press[0], m_delay, m_state);
            end else n_pass++;
            n_checks++;
            if (n == 20) begin
                if (btn_state !== 3'b111 || delay !== 4'd13) begin
                    $display("[TB] FAIL simul_held: got state=%b delay=%0d, expected 111/13", btn_state, delay);
                end else n_pass++;
                n_checks++;
            end
        end
        if (pulses != 1) begin
            $display("[TB] FAIL simul_pause: got %0d strobes, expected 1", pulses);
        end else n_pass++;
        n_checks++;
    endtask

    task automatic test_mid_reset();
        int pulses;
        press_once(1, "mid_prep");
        if (delay !== 4'd12) begin
            $display("[TB] FAIL mid_prep_delay: got delay=%0d, expected 12", delay);
        end else n_pass++;
        n_checks++;
        btn_n[0] = 1'b0;
        repeat (4) tick();
        reset_n = 1'b0;
        btn_n   = 3'b111;
        tick();
        if ({pause, delay, btn_state} !== {1'b0, 4'(DI), 3'b000}) begin
            $display("[TB] FAIL mid_reset_values: got %b/%0d/%b, expected 0/%0d/000", pause, delay, btn_state, DI);
        end else n_pass++;
        n_checks++;
        reset_n = 1'b1;
        pulses  = 0;
        for (int n = 1; n <= 15; n++) begin
            tick();
            if (pause) pulses++;
            if ({pause, delay, btn_state} !== {m_press[0], m_delay, m_state}) begin
                $display("[TB] FAIL mid_after n=%0d: got %b/%0d/%b, expected %b/%0d/%b", n, pause, delay, btn_state, m_press[0], m_delay, m_state);
            end else n_pass++;
            n_checks++;
        end
        if (pulses != 0) begin
            $display("[TB] FAIL mid_aborted_press: got %0d strobes, expected 0", pulses);
        end else n_pass++;
        n_checks++;
    endtask

    task automatic test_random();
        for (int s = 0; s < 60; s++) begin
            int dur;
            reset_n = ($urandom_range(0, 24) == 0) ? 1'b0 : 1'b1;
            btn_n   = 3'($urandom);
            dur     = (reset_n == 1'b0) ? 1 : $urandom_range(1, 16);
            for (int n = 0; n < dur; n++) begin
                tick();
                if ({pause, delay, btn_state} !== {m_press[0], m_delay, m_state}) begin
                    $display("[TB] FAIL random seg=%0d n=%0d: got %b/%0d/%b, expected %b/%0d/%b", s, n, pause, delay, btn_state, m_press[0], m_delay, m_state);
                end else n_pass++;
                n_checks++;
            end
            reset_n = 1'b1;
        end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) hist[i] = '0;
        for (int c = 0; c < 3; c++) begin
            rise_edge[c] = 0;
            rise_ok[c]   = 1'b0;
        end
        reset_n = 1'b0;
        btn_n   = 3'b000;
        $display("[TB] button_ctrl bench starting");
        test_reset();
        test_glitch();
        test_saturation();
        test_repeat();
        test_simultaneous();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
